prog_ctr_stack: RTL and testbench

Parametrised next-generation program counter for the single-cycle CSE141L core. It adds:
- configurable PC width
- absolute or PC-relative branch targets
- a hardware call/return stack
- an explicit run/halt/fault state machine
It sits between the control decoder and instruction ROM address port. ProgCtr drives the instruction fetch address every cycle.

---
 rtl/prog_ctr_pkg.sv | 26 ++
 rtl/prog_ctr_stack_ret_stack.sv | 62 ++++++
 rtl/prog_ctr_stack.sv | 151 +++++++++++++++
 tb/tb_prog_ctr_stack.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/prog_ctr_pkg.sv
// prog_ctr_pkg
// Shared types for the program counter with call/return stack.
//   state_t    : run-control state (IDLE, RUN, HALTED, FAULT), 2-bit encoding
//   pc_src_t   : selects where the next program counter value comes from
// Used by prog_ctr_stack. The optional bounds check is enabled by defining
// PROG_CTR_BOUNDS_EN; it is implemented in prog_ctr_stack.sv.
package prog_ctr_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2,
    FAULT  = 2'd3
  } state_t;

  typedef enum logic [2:0] {
    HOLD   = 3'd0,
    INC    = 3'd1,
    BR_ABS = 3'd2,
    BR_REL = 3'd3,
    CALL   = 3'd4,
    RET    = 3'd5,
    START  = 3'd6
  } pc_src_t;

endpackage

// File: rtl/prog_ctr_stack_ret_stack.sv
// ret_stack
// Return-address LIFO for the program counter.
// Ports:
//   clock    : rising-edge clock
//   reset    : asynchronous active-high, empties the stack
//   clear    : synchronous pointer reset (entries are left as they are)
//   push     : write pushData on top (ignored when full)
//   pop      : discard the top entry (ignored when empty)
//   pushData : return address to store
//   top      : most recently pushed entry, don't-care when empty
//   empty    : no valid entries
//   full     : STACK_DEPTH valid entries
module ret_stack #(
  parameter int PC_W        = 10,
  parameter int STACK_DEPTH = 4
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            clear,
  input  logic            push,
  input  logic            pop,
  input  logic [PC_W-1:0] pushData,
  output logic [PC_W-1:0] top,
  output logic            empty,
  output logic            full
);

  localparam int PTR_W = $clog2(STACK_DEPTH + 1);
  localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam logic [PTR_W-1:0] FULL_PTR = PTR_W'(STACK_DEPTH);

  logic [PTR_W-1:0] ptr;
  logic [PTR_W-1:0] ptrDec;
  logic [PC_W-1:0]  entries [0:(1<<IDX_W)-1];

  assign ptrDec = ptr - PTR_W'(1);
  assign empty  = (ptr == '0);
  assign full   = (ptr == FULL_PTR);
  assign top    = entries[ptrDec[IDX_W-1:0]];

  // Pointer counts valid entries; clear takes priority so a restart always
  // begins with an empty stack.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ptr <= '0;
    end else if (clear) begin
      ptr <= '0;
    end else if (push && !full) begin
      ptr <= ptr + PTR_W'(1);
    end else if (pop && !empty) begin
      ptr <= ptrDec;
    end
  end

  // Entry storage needs no reset: only entries below the pointer are ever read.
  always_ff @(posedge clock) begin
    if (push && !full && !clear) begin
      entries[ptr[IDX_W-1:0]] <= pushData;
    end
  end

endmodule

// File: rtl/prog_ctr_stack.sv
// prog_ctr_stack
// Program counter with absolute/relative branches, call/return stack and a
// run/halt/fault state machine. ProgCtr is registered; every update appears
// one edge after the controlling inputs are sampled.
// Ports:
//   Clk, Reset          : clock, asynchronous active-high reset
//   Start               : launch from START_ADDR (IDLE/HALTED/FAULT only)
//   Halt                : stop fetching, hold PC
//   Branch, ConditionalBranch, Flag, RelMode, Target : branch control
//   Call, Ret           : push PC+1 and jump / pop return address
//   ProgCtr             : fetch address
//   Running, Done, Fault: state decode (RUN, HALTED, FAULT)
//   StackEmpty, StackFull : return stack status
// Optional feature: define PROG_CTR_BOUNDS_EN to fault on any next PC above
// MAX_ADDR while running.
module prog_ctr_stack
  import prog_ctr_pkg::*;
#(
  parameter int              PC_W        = 10,
  parameter int              STACK_DEPTH = 4,
  parameter logic [PC_W-1:0] START_ADDR  = '0,
  parameter logic [PC_W-1:0] MAX_ADDR    = '1
) (
  input  logic            Clk,
  input  logic            Reset,
  input  logic            Start,
  input  logic            Halt,
  input  logic            Branch,
  input  logic            ConditionalBranch,
  input  logic            Flag,
  input  logic            RelMode,
  input  logic            Call,
  input  logic            Ret,
  input  logic [PC_W-1:0] Target,
  output logic [PC_W-1:0] ProgCtr,
  output logic            Running,
  output logic            Done,
  output logic            Fault,
  output logic            StackEmpty,
  output logic            StackFull
);

  state_t          state;
  state_t          nextState;
  pc_src_t         pcSrc;
  logic [PC_W-1:0] nextPc;
  logic [PC_W-1:0] incPc;
  logic [PC_W-1:0] topAddr;
  logic            taken;
  logic            push;
  logic            pop;
  logic            clear;

  assign taken = Branch & (~ConditionalBranch | Flag);
  assign incPc = ProgCtr + PC_W'(1);

  ret_stack #(
    .PC_W        (PC_W),
    .STACK_DEPTH (STACK_DEPTH)
  ) u_ret_stack (
    .clock    (Clk),
    .reset    (Reset),
    .clear    (clear),
    .push     (push),
    .pop      (pop),
    .pushData (incPc),
    .top      (topAddr),
    .empty    (StackEmpty),
    .full     (StackFull)
  );

  // Next-state and next-PC selection. Inside RUN the checks are ordered so
  // Halt beats everything, a Call/Ret conflict beats either alone, and
  // branches are only considered when neither Call nor Ret is active.
  always_comb begin
    nextState = state;
    pcSrc     = HOLD;
    case (state)
      RUN: begin
        if (Halt) begin
          nextState = HALTED;
        end else if (Call && Ret) begin
          nextState = FAULT;
        end else if (Ret) begin
          if (StackEmpty) nextState = FAULT;
          else            pcSrc     = RET;
        end else if (Call) begin
          if (StackFull) nextState = FAULT;
          else           pcSrc     = CALL;
        end else if (taken) begin
          pcSrc = RelMode ? BR_REL : BR_ABS;
        end else begin
          pcSrc = INC;
        end
      end
      default: begin
        if (Start) begin
          nextState = RUN;
          pcSrc     = START;
        end
      end
    endcase

    // Relative targets are two's-complement offsets; at PC_W bits the
    // plain sum already equals PC + sign-extended offset modulo 2^PC_W.
    case (pcSrc)
      INC:     nextPc = incPc;
      BR_ABS:  nextPc = Target;
      BR_REL:  nextPc = ProgCtr + Target;
      CALL:    nextPc = Target;
      RET:     nextPc = topAddr;
      START:   nextPc = START_ADDR;
      default: nextPc = ProgCtr;
    endcase

`ifdef PROG_CTR_BOUNDS_EN
    // An out-of-range destination faults instead of moving, and must not
    // disturb the stack either.
    if (state == RUN && pcSrc != HOLD && nextPc > MAX_ADDR) begin
      nextState = FAULT;
      pcSrc     = HOLD;
      nextPc    = ProgCtr;
    end
`endif

    push  = (pcSrc == CALL);
    pop   = (pcSrc == RET);
    clear = (pcSrc == START);
  end

`ifndef PROG_CTR_BOUNDS_EN
  logic unusedMaxAddr;
  assign unusedMaxAddr = ^MAX_ADDR;
`endif

  // State and PC registers; reset parks the core in IDLE at START_ADDR.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state   <= IDLE;
      ProgCtr <= START_ADDR;
    end else begin
      state   <= nextState;
      ProgCtr <= nextPc;
    end
  end

  assign Running = (state == RUN);
  assign Done    = (state == HALTED);
  assign Fault   = (state == FAULT);

endmodule

// File: tb/tb_prog_ctr_stack.sv
// tb_prog_ctr_stack
// Self-checking bench for prog_ctr_stack (PC_W=10, STACK_DEPTH=4). A
// queue-based reference model tracks PC, run state and return stack.
// Define PROG_CTR_BOUNDS_EN to build the bounds-checked variant with
// MAX_ADDR=50.
module tb_prog_ctr_stack;

  localparam int PC_W    = 10;
  localparam int DEPTH   = 4;
  localparam int MOD     = 1 << PC_W;
  localparam int START_A = 0;
`ifdef PROG_CTR_BOUNDS_EN
  localparam int MAX_A = 50;
`else
  localparam int MAX_A = MOD - 1;
`endif

  localparam int S_IDLE  = 0;
  localparam int S_RUN   = 1;
  localparam int S_HALT  = 2;
  localparam int S_FAULT = 3;

  logic            Clk = 1'b0;
  logic            Reset = 1'b1;
  logic            Start = 1'b0, Halt = 1'b0, Branch = 1'b0;
  logic            ConditionalBranch = 1'b0, Flag = 1'b0, RelMode = 1'b0;
  logic            Call = 1'b0, Ret = 1'b0;
  logic [PC_W-1:0] Target = '0;
  logic [PC_W-1:0] ProgCtr;
  logic            Running, Done, Fault, StackEmpty, StackFull;

  int vectors = 0;
  int miscompares = 0;

  int mState = S_IDLE;
  int mPc = START_A;
  int mStack[$];

  wire [PC_W+4:0] obs = {ProgCtr, Running, Done, Fault, StackEmpty, StackFull};

  prog_ctr_stack #(
    .PC_W        (PC_W),
    .STACK_DEPTH (DEPTH),
    .START_ADDR  (PC_W'(START_A)),
    .MAX_ADDR    (PC_W'(MAX_A))
  ) dut (
    .Clk               (Clk),
    .Reset             (Reset),
    .Start             (Start),
    .Halt              (Halt),
    .Branch            (Branch),
    .ConditionalBranch (ConditionalBranch),
    .Flag              (Flag),
    .RelMode           (RelMode),
    .Call              (Call),
    .Ret               (Ret),
    .Target            (Target),
    .ProgCtr           (ProgCtr),
    .Running           (Running),
    .Done              (Done),
    .Fault             (Fault),
    .StackEmpty        (StackEmpty),
    .StackFull         (StackFull)
  );

  always #5 Clk = ~Clk;

  function automatic logic [PC_W+4:0] expVec();
    return {PC_W'(mPc), mState == S_RUN, mState == S_HALT, mState == S_FAULT,
            mStack.size() == 0, mStack.size() == DEPTH};
  endfunction

  function automatic int wrapPc(input int x);
    return ((x % MOD) + MOD) % MOD;
  endfunction

  task automatic modelReset();
    mState = S_IDLE;
    mPc    = START_A;
    mStack.delete();
  endtask

  task automatic modelStep(input bit st, hl, br, cb, fl, rm, ca, re, input int tg);
    int np;
    int off;
    if (mState != S_RUN) begin
      if (st) begin
        mPc = START_A;
        mStack.delete();
        mState = S_RUN;
      end
      return;
    end
    if (hl) begin mState = S_HALT; return; end
    if (ca && re) begin mState = S_FAULT; return; end
    if (re) begin
      if (mStack.size() == 0) begin mState = S_FAULT; return; end
      np = mStack[$];
    end else if (ca) begin
      if (mStack.size() == DEPTH) begin mState = S_FAULT; return; end
      np = tg;
    end else if (br && (!cb || fl)) begin
      off = (tg >= MOD / 2) ? tg - MOD : tg;
      np = rm ? wrapPc(mPc + off) : tg;
    end else begin
      np = wrapPc(mPc + 1);
    end
    if (np > MAX_A) begin mState = S_FAULT; return; end
    if (re) void'(mStack.pop_back());
    else if (ca) mStack.push_back(wrapPc(mPc + 1));
    mPc = np;
  endtask

  // Drives one cycle of inputs, advances the model, samples 1 after the edge.
  task automatic step(input bit st, hl, br, cb, fl, rm, ca, re, input int tg);
    Start = st; Halt = hl; Branch = br; ConditionalBranch = cb; Flag = fl;
    RelMode = rm; Call = ca; Ret = re; Target = PC_W'(tg);
    modelStep(st, hl, br, cb, fl, rm, ca, re, tg);
    @(posedge Clk);
    #1;
  endtask

  task automatic applyStimulus(input bit st, hl, br, cb, fl, rm, ca, re, input int tg);
    step(st, hl, br, cb, fl, rm, ca, re, tg);
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    repeat (2) @(posedge Clk);
    #1;
    modelReset();
    vectors++;
    if (obs !== {PC_W'(0), 5'b00010}) begin
      miscompares++;
      $display("[TB] FAIL reset_state: got %h expected %h", obs, {PC_W'(0), 5'b00010});
    end
    Reset = 1'b0;
  endtask

  task automatic test_start_count();
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
    vectors++;
    if (ProgCtr !== 10'd0 || Running !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL start: got pc=%0d run=%b expected pc=0 run=1", ProgCtr, Running);
    end
    for (int i = 0; i < 10; i++) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    vectors++;
    if (ProgCtr !== 10'd10 || obs !== expVec()) begin
      miscompares++;
      $display("[TB] FAIL count10: got %h expected pc=10 model %h", obs, expVec());
    end
  endtask

  task automatic test_branch();
    applyStimulus(0, 0, 1, 0, 0, 0, 0, 0, 5);
    applyStimulus(0, 0, 1, 1, 0, 0, 0, 0, 77);
    vectors++;
    if (ProgCtr !== 10'd6) begin
      miscompares++;
      $display("[TB] FAIL cond_not_taken: got %0d expected 6", ProgCtr);
    end
    applyStimulus(0, 0, 1, 1, 1, 0, 0, 0, 100);
    vectors++;
    if (ProgCtr !== 10'd100) begin
      miscompares++;
      $display("[TB] FAIL cond_taken: got %0d expected 100", ProgCtr);
    end
    applyStimulus(0, 0, 1, 1, 1, 1, 0, 0, MOD - 4);
    vectors++;
    if (ProgCtr !== 10'd96 || obs !== expVec()) begin
      miscompares++;
      $display("[TB] FAIL rel_branch: got %h expected pc=96 model %h", obs, expVec());
    end
  endtask

  task automatic test_call_ret();
    applyStimulus(0, 0, 1, 0, 0, 0, 0, 0, 20);
    applyStimulus(0, 0, 1, 0, 0, 0, 1, 0, 200);
    vectors++;
    if (ProgCtr !== 10'd200 || StackEmpty !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL call: got pc=%0d empty=%b expected pc=200 empty=0", ProgCtr, StackEmpty);
    end
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0);
    vectors++;
    if (ProgCtr !== 10'd21 || StackEmpty !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL ret: got pc=%0d empty=%b expected pc=21 empty=1", ProgCtr, StackEmpty);
    end
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0);
    vectors++;
    if (ProgCtr !== 10'd21 || Fault !== 1'b1 || Running !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL ret_empty: got pc=%0d fault=%b expected pc=21 fault=1", ProgCtr, Fault);
    end
  endtask

  task automatic test_stack_full();
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 0, 0, 0, 0, 0, 1, 0, 100 + 10 * i);
      vectors++;
      if (StackFull !== (i == 3) || obs !== expVec()) begin
        miscompares++;
        $display("[TB] FAIL nested_call%0d: got %h expected %h", i, obs, expVec());
      end
    end
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 0, 140);
    vectors++;
    if (Fault !== 1'b1 || ProgCtr !== 10'd130) begin
      miscompares++;
      $display("[TB] FAIL call_full: got pc=%0d fault=%b expected pc=130 fault=1", ProgCtr, Fault);
    end
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
    vectors++;
    if (obs !== {PC_W'(0), 5'b10010}) begin
      miscompares++;
      $display("[TB] FAIL restart: got %h expected %h", obs, {PC_W'(0), 5'b10010});
    end
  endtask

  task automatic test_wrap();
    applyStimulus(0, 0, 1, 0, 0, 0, 0, 0, MOD - 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    vectors++;
    if (ProgCtr !== 10'd0 || Fault !== 1'b0 || Running !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL wrap: got pc=%0d fault=%b expected pc=0 fault=0", ProgCtr, Fault);
    end
  endtask

  task automatic test_bounds();
    applyStimulus(0, 0, 1, 0, 0, 0, 0, 0, 45);
    for (int i = 0; i < 6; i++) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    vectors++;
    if (ProgCtr !== 10'd50 || Fault !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL bounds: got pc=%0d fault=%b expected pc=50 fault=1", ProgCtr, Fault);
    end
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_halt();
    applyStimulus(0, 0, 1, 0, 0, 0, 0, 0, 30);
    applyStimulus(0, 1, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 20; i++) begin
      applyStimulus(0, 0, i[0], 0, 1, 0, 0, 0, $urandom_range(0, MOD - 1));
      vectors++;
      if (ProgCtr !== 10'd30 || Done !== 1'b1 || obs !== expVec()) begin
        miscompares++;
        $display("[TB] FAIL halt_hold%0d: got %h expected %h", i, obs, expVec());
      end
    end
  endtask

  task automatic test_reset_mid_call();
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 0, 30);
    Call = 1'b1;
    Target = 10'd40;
    #2;
    Reset = 1'b1;
    modelReset();
    #1;
    vectors++;
    if (obs !== {PC_W'(0), 5'b00010}) begin
      miscompares++;
      $display("[TB] FAIL reset_mid_call: got %h expected %h", obs, {PC_W'(0), 5'b00010});
    end
    #2;
    Reset = 1'b0;
    Call = 1'b0;
    applyStimulus(0, 0, 1, 0, 0, 0, 1, 0, 9);
    vectors++;
    if (obs !== expVec()) begin
      miscompares++;
      $display("[TB] FAIL idle_after_reset: got %h expected %h", obs, expVec());
    end
  endtask

  task automatic test_random();
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 400; i++) begin
      applyStimulus($urandom_range(0, 99) < 6, $urandom_range(0, 99) < 3,
                    $urandom_range(0, 99) < 40, $urandom_range(0, 1) == 1,
                    $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                    $urandom_range(0, 99) < 15, $urandom_range(0, 99) < 12,
                    $urandom_range(0, MAX_A));
      vectors++;
      if (obs !== expVec()) begin
        miscompares++;
        $display("[TB] FAIL random%0d: got %h expected %h", i, obs, expVec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_start_count();
`ifdef PROG_CTR_BOUNDS_EN
    test_bounds();
`else
    test_branch();
    test_call_ret();
    test_stack_full();
    test_wrap();
    test_halt();
`endif
    test_reset_mid_call();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
